// File: rtl/alu_uart_if_if.sv
// alu_uart_if_if
//   Signal bundle between the frame sequencer (alu_uart_if), the UART
//   receiver/transmitter and the combinational ALU.
//   slave  : sequencer view (takes rx/tx status and ALU result, drives the
//            ALU operands, the transmit byte and the status pulses)
//   master : environment view (UART + ALU side), directions mirrored
// Signals:
//   i_rx_data/i_rx_valid  received byte and its one-cycle strobe
//   i_tx_busy             transmitter busy
//   i_alu_result          combinational ALU result
//   o_data_a/o_data_b     operands held for the ALU
//   o_op                  opcode held for the ALU
//   o_tx_data/o_tx_start  result byte and one-cycle transmit request
//   o_overrun             one-cycle pulse when a received byte is dropped
//   o_busy                high while a result is being produced or sent
interface alu_uart_if_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) ();
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               i_tx_busy;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_overrun;
    logic               o_busy;

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_alu_result,
        output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_overrun, o_busy
    );

    modport master (
        output i_rx_data, i_rx_valid, i_tx_busy, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_overrun, o_busy
    );
endinterface

// File: rtl/alu_uart_if.sv
// alu_uart_if
//   Frame sequencer around a combinational ALU. Collects operand A, operand B
//   and opcode bytes from the UART receiver, holds them on the ALU inputs,
//   captures the result and hands it to the UART transmitter. One frame in
//   flight; bytes arriving while a result is pending are dropped and flagged
//   on o_overrun.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      alu_uart_if_if.slave (rx byte/strobe, tx busy, ALU result in;
//            operands, opcode, tx byte/start, overrun, busy out)
// Build option:
//   ALU_UART_IF_TIMEOUT_EN  when defined, an idle timer aborts a partial frame
//   after TIMEOUT_CYCLES cycles without a byte in WAIT_B/WAIT_OP, returning to
//   WAIT_A with an o_overrun pulse. When undefined, no timer exists and the
//   FSM waits indefinitely for the next byte.
//
// state   | meaning
// --------+-------------------------------------------------------------
// WAIT_A  | idle, next byte is operand A
// WAIT_B  | A captured, next byte is operand B
// WAIT_OP | A and B captured, next byte is the opcode
// EXEC    | one cycle, ALU inputs stable, result captured at end of cycle
// SEND    | result held, request transmit as soon as tx is not busy
module alu_uart_if #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_uart_if_if.slave bus
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } state_t;

    state_t             state;
    logic [NB_DATA-1:0] data_a;
    logic [NB_DATA-1:0] data_b;
    logic [NB_OP-1:0]   op;
    logic [NB_DATA-1:0] tx_data;
    logic               overrun;
    logic               busy;
    logic               timeout_hit;

`ifdef ALU_UART_IF_TIMEOUT_EN
    localparam int NB_CNT = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    logic [NB_CNT-1:0] idle_cnt;
    logic              in_wait_mid;

    assign in_wait_mid = (state == WAIT_B) || (state == WAIT_OP);
    assign timeout_hit = in_wait_mid && !bus.i_rx_valid && (idle_cnt == CNT_LAST);

    // Counts only idle cycles inside a partial frame; any byte, any other
    // state, or the timeout itself brings it back to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt <= '0;
        end else if (in_wait_mid && !bus.i_rx_valid && !timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= WAIT_A;
            data_a  <= '0;
            data_b  <= '0;
            op      <= '0;
            tx_data <= '0;
            overrun <= 1'b0;
            busy    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (bus.i_rx_valid) begin
                        data_a <= bus.i_rx_data;
                        state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_valid) begin
                        data_b <= bus.i_rx_data;
                        state  <= WAIT_OP;
                    end else if (timeout_hit) begin
                        overrun <= 1'b1;
                        state   <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (bus.i_rx_valid) begin
                        op    <= bus.i_rx_data[NB_OP-1:0];
                        busy  <= 1'b1;
                        state <= EXEC;
                    end else if (timeout_hit) begin
                        overrun <= 1'b1;
                        state   <= WAIT_A;
                    end
                end
                EXEC: begin
                    tx_data <= bus.i_alu_result;
                    overrun <= bus.i_rx_valid;
                    state   <= SEND;
                end
                SEND: begin
                    // A byte landing on the same cycle as the transmit request
                    // still belongs to the pending frame and is dropped.
                    overrun <= bus.i_rx_valid;
                    if (!bus.i_tx_busy) begin
                        busy  <= 1'b0;
                        state <= WAIT_A;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_data_a   = data_a;
    assign bus.o_data_b   = data_b;
    assign bus.o_op       = op;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_overrun  = overrun;
    assign bus.o_busy     = busy;
    // Combinational on i_tx_busy so the request lands in the same SEND cycle
    // the transmitter becomes free.
    assign bus.o_tx_start = (state == SEND) && !bus.i_tx_busy;

endmodule

// File: tb/tb_alu_uart_if.sv
module tb_alu_uart_if;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TOUT    = 16;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
    } exp_t;

    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   errors;
    int   exp_ovr;
    int   seen_ovr;
    exp_t exp_q[$];

    alu_uart_if_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    alu_uart_if #(
        .NB_DATA       (NB_DATA),
        .NB_OP         (NB_OP),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural ALU on the environment side of the sequencer.
    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [5:0] op);
        case (op)
            6'h08:   return a + b;
            6'h0A:   return a - b;
            6'h0C:   return a & b;
            6'h0D:   return a | b;
            6'h0E:   return a ^ b;
            6'h0F:   return ~(a | b);
            6'h02:   return a >> b;
            6'h03:   return $unsigned($signed(a) >>> b);
            default: return {2'b00, op} ^ a;
        endcase
    endfunction

    always_comb bus.i_alu_result = alu_f(bus.o_data_a, bus.o_data_b, bus.o_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every transmit request pops one expected frame.
    always @(negedge i_clk) begin
        if (i_rst_n && bus.o_overrun === 1'b1) seen_ovr++;
        if (i_rst_n && bus.o_tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tx_start", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tx_data", 32'(bus.o_tx_data), 32'(e.res));
                chk("data_a",  32'(bus.o_data_a),  32'(e.a));
                chk("data_b",  32'(bus.o_data_b),  32'(e.b));
                chk("op",      32'(bus.o_op),      32'(e.op));
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        step();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [7:0] res, input int busy_n, input int gap,
                         input bit inj_exec, input bit inj_send);
        exp_t e;
        e.a = a; e.b = b; e.op = opb[5:0]; e.res = res;
        exp_q.push_back(e);
        send_byte(a);
        idle(gap);
        send_byte(b);
        idle(gap);
        bus.i_tx_busy = (busy_n > 0);
        send_byte(opb);
        #1;
        chk("busy_in_exec", 32'(bus.o_busy), 32'd1);
        chk("no_start_in_exec", 32'(bus.o_tx_start), 32'd0);
        if (inj_exec) begin
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = 8'($urandom);
            exp_ovr++;
        end
        step();
        bus.i_rx_valid = 1'b0;
        for (int k = 0; k < busy_n; k++) begin
            #1;
            chk("hold_no_start", 32'(bus.o_tx_start), 32'd0);
            chk("hold_busy", 32'(bus.o_busy), 32'd1);
            chk("hold_tx_data", 32'(bus.o_tx_data), 32'(res));
            if (inj_send && k == 0) begin
                bus.i_rx_valid = 1'b1;
                bus.i_rx_data  = 8'h55;
                exp_ovr++;
            end
            step();
            bus.i_rx_valid = 1'b0;
            if (inj_send && k == 0) begin
                #1;
                chk("overrun_pulse", 32'(bus.o_overrun), 32'd1);
            end
        end
        bus.i_tx_busy = 1'b0;
        #1;
        chk("tx_start_in_send", 32'(bus.o_tx_start), 32'd1);
        step();
        #1;
        chk("idle_after_send", 32'(bus.o_busy), 32'd0);
        chk("no_start_after_send", 32'(bus.o_tx_start), 32'd0);
        chk("overrun_single", 32'(bus.o_overrun), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops[8];
        logic [7:0] a, b, opb;
        checks = 0; errors = 0; exp_ovr = 0; seen_ovr = 0;
        ops[0] = 8'h08; ops[1] = 8'h0A; ops[2] = 8'h0C; ops[3] = 8'h0D;
        ops[4] = 8'h0E; ops[5] = 8'h0F; ops[6] = 8'h02; ops[7] = 8'h03;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_tx_busy  = 1'b0;
        i_rst_n = 1'b0;
        idle(3);
        #1;
        chk("rst_data_a", 32'(bus.o_data_a), 32'd0);
        chk("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_start", 32'(bus.o_tx_start), 32'd0);
        i_rst_n = 1'b1;
        idle(2);

        frame(8'h05, 8'h03, 8'h08, 8'h08, 0, 0, 1'b0, 1'b0);
        frame(8'h80, 8'h02, 8'h03, 8'hE0, 0, 1, 1'b0, 1'b0);
        frame(8'h80, 8'h02, 8'h02, 8'h20, 0, 0, 1'b0, 1'b0);
        frame(8'h05, 8'h07, 8'h0A, 8'hFE, 10, 0, 1'b0, 1'b0);
        frame(8'h09, 8'h04, 8'hC8, 8'h0D, 3, 0, 1'b0, 1'b1);
        frame(8'h01, 8'h01, 8'h08, 8'h02, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        send_byte(8'h11);
        send_byte(8'h22);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_a", 32'(bus.o_data_a), 32'd0);
        chk("async_rst_b", 32'(bus.o_data_b), 32'd0);
        chk("async_rst_tx", 32'(bus.o_tx_data), 32'd0);
        chk("async_rst_busy", 32'(bus.o_busy), 32'd0);
        step();
        i_rst_n = 1'b1;
        idle(1);
        frame(8'h01, 8'h02, 8'h08, 8'h03, 0, 0, 1'b0, 1'b0);

        // Long idle after operand A.
        send_byte(8'h40);
        idle(TOUT - 1);
        #1;
        chk("no_early_timeout", 32'(bus.o_overrun), 32'd0);
        step();
        #1;
`ifdef ALU_UART_IF_TIMEOUT_EN
        chk("timeout_overrun", 32'(bus.o_overrun), 32'd1);
        exp_ovr++;
        frame(8'h0F, 8'hF0, 8'h0D, 8'hFF, 0, 0, 1'b0, 1'b0);
`else
        chk("wait_no_timeout", 32'(bus.o_overrun), 32'd0);
        exp_q.push_back('{a: 8'h40, b: 8'h02, op: 6'h08, res: 8'h42});
        send_byte(8'h02);
        send_byte(8'h08);
        idle(1);
        #1;
        chk("late_frame_start", 32'(bus.o_tx_start), 32'd1);
        step();
`endif

        for (int n = 0; n < 24; n++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) opb = 8'($urandom);
            else opb = {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
            frame(a, b, opb, alu_f(a, b, opb[5:0]), $urandom_range(0, 4),
                  $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0));
        end

        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("overrun_count", 32'(seen_ovr), 32'(exp_ovr));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
